fifo_drain_ram: RTL and testbench
=================================

Name: fifo_drain_ram

Overview:
Parametrised FIFO-to-RAM drain engine, the successor to the fixed 10-word fifoa2b consumer.
- On a run request it optionally polls the producer FIFO's check_finished method until it returns true.
- It then dequeues a runtime-selected number of words into an internal dual-port RAM, starting at a runtime base address and wrapping modulo WORDS.
- RAM port 0 is exported for host read/write; port 1 is owned by the engine.

Parameters:
DWIDTH, 32, data word width of FIFO and RAM
AWIDTH, 4, RAM address width
WORDS, 10, RAM depth (WORDS <= 2**AWIDTH)

Ports:
clock  in  1  system clock
reset  in  1  synchronous reset, active-high
ce  in  1  clock enable; when low all registers hold and both RAM ports are disabled
i_run_req  in  1  start pulse, sampled only in IDLE
i_run_count  in  AWIDTH+1  number of words to drain, latched at start
i_run_base  in  AWIDTH  first RAM address, latched at start
i_run_wait_finished  in  1  1 = poll check_finished before draining, latched at start
o_run_busy  out  1  high from the cycle after an accepted start until DONE exits
o_run_done_count  out  AWIDTH+1  words written in the current or last run
o_fifo_check_finished_req  out  1  method-call request to the FIFO
i_fifo_check_finished_busy  in  1  FIFO busy
i_fifo_check_finished_return  in  1  FIFO finished flag
o_fifo_deque_req  out  1  method-call request to the FIFO
i_fifo_deque_busy  in  1  FIFO busy
i_fifo_deque_return  in  DWIDTH  dequeued word
i_ram_addr_0  in  AWIDTH  host port address
i_ram_datain_0  in  DWIDTH  host write data
i_ram_r_w_0  in  1  1 = write
o_ram_dataout_0  out  DWIDTH  host read data, 1-cycle latency

Behaviour:
- Reset values: o_run_busy=0, o_run_done_count=0, both req outputs=0, port-1 r_w=0, FSM=IDLE. RAM contents are not cleared.
- All behaviour below applies only in cycles where ce=1.
- Method-call handshake, 4 cycles minimum:
  - REQ: req=1.
  - HOLD: req=0.
  - WAIT: stay while busy=1; on busy=0 capture the return value.
  - Then proceed to the next state.
- IDLE:
  - On i_run_req, latch count (clamped to WORDS if larger), base (forced to 0 if >= WORDS) and wait_finished.
  - Clear done_count and set busy.
  - If wait_finished=1, go to POLL_REQ; else go to CHECK_CNT.
- POLL_REQ -> POLL_HOLD -> POLL_WAIT:
  - Return=1 goes to CHECK_CNT.
  - Return=0 goes back to POLL_REQ with no idle gap.
- CHECK_CNT: if done_count == count go to DONE, else go to DEQ_REQ.
- DEQ_REQ -> DEQ_HOLD -> DEQ_WAIT: capture the return into the port-1 data register.
- WRITE:
  - Port 1 writes the captured word at addr_ptr.
  - done_count increments.
  - addr_ptr = (addr_ptr == WORDS-1) ? 0 : addr_ptr+1.
  - Go to CHECK_CNT.
- Throughput with the FIFO never busy: 5 cycles per word.
- DONE: lasts 1 cycle; busy=0 on exit, port-1 r_w=0, return to IDLE. done_count holds until the next start.
- count=0 (after clamping): IDLE -> CHECK_CNT -> DONE. No deque is issued; busy is high for 2 cycles.
- i_run_req while busy: ignored, not queued.
- Same-address write collision on both RAM ports in one cycle: port 1 (engine) wins. Read-during-write on port 0 returns old data.
- Reset mid-run: next cycle FSM=IDLE and req outputs=0. Any in-flight FIFO call is abandoned, and the FIFO is responsible for its own recovery.
- Address arithmetic is done in AWIDTH+1 bits, so there is no overflow when WORDS = 2**AWIDTH.

Decomposition:
- Shared package: FSM state enum (IDLE, POLL_REQ, POLL_HOLD, POLL_WAIT, CHECK_CNT, DEQ_REQ, DEQ_HOLD, DEQ_WAIT, WRITE, DONE).
- Sub-module: dual_port_ram (DWIDTH, AWIDTH, WORDS). Synchronous, per-port ce, port-1 write priority on collision.

Test Plan:
1. wait_finished=0, count=10, base=0, FIFO returns 100..109 with busy never high -> RAM[0..9]=100..109; busy high for 52 cycles; done_count=10.
2. wait_finished=1, check_finished returns 0,0,1 -> exactly 3 check calls and no deque before the third return; then drain proceeds.
3. WORDS=10, base=7, count=5, data 1..5 -> RAM[7,8,9,0,1]=1..5; RAM[2..6] unchanged.
4. count=0 -> no deque_req ever asserted, busy high for 2 cycles; count=15 -> clamped, exactly 10 deques.
5. deque_busy held for 6 cycles on word 3; ce dropped for 4 cycles mid-run -> data and addresses are still correct; latency grows by exactly the stall cycles.
6. Reset asserted during DEQ_WAIT of word 4 -> next cycle busy=0 and reqs=0; RAM[0..2] retained; a new run starts cleanly.

Source files
------------

// File: rtl/fifo_drain_ram_pkg.sv
// Shared types for the FIFO-to-RAM drain engine.
package fifo_drain_ram_pkg;

   typedef enum logic [3:0] {
      IDLE,
      POLL_REQ,
      POLL_HOLD,
      POLL_WAIT,
      CHECK_CNT,
      DEQ_REQ,
      DEQ_HOLD,
      DEQ_WAIT,
      WRITE,
      DONE
   } state_t;

endpackage

// File: rtl/fifo_drain_ram_dual_port_ram.sv
// Synchronous dual-port RAM; port 0 read/write, port 1 write-only with priority on collision.
module dual_port_ram #(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4,
   parameter int WORDS  = 10
) (
   input  logic              clock,
   input  logic              ce_0,
   input  logic [AWIDTH-1:0] addr_0,
   input  logic [DWIDTH-1:0] datain_0,
   input  logic              r_w_0,
   output logic [DWIDTH-1:0] dataout_0,
   input  logic              ce_1,
   input  logic [AWIDTH-1:0] addr_1,
   input  logic [DWIDTH-1:0] datain_1,
   input  logic              r_w_1
);

   logic [DWIDTH-1:0] mem [WORDS];

   // Port 1 is written last so it wins a same-address collision; port 0 reads old data.
   always_ff @(posedge clock) begin
      if (ce_0) begin
         dataout_0 <= mem[addr_0];
         if (r_w_0 && (32'(addr_0) < WORDS))
            mem[addr_0] <= datain_0;
      end
      if (ce_1 && r_w_1 && (32'(addr_1) < WORDS))
         mem[addr_1] <= datain_1;
   end

endmodule

// File: rtl/fifo_drain_ram.sv
// Drain engine: optionally polls check_finished, then dequeues N words into RAM at a wrapping address.
module fifo_drain_ram
   import fifo_drain_ram_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int AWIDTH = 4,
   parameter int WORDS  = 10
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              ce,
   input  logic              i_run_req,
   input  logic [AWIDTH:0]   i_run_count,
   input  logic [AWIDTH-1:0] i_run_base,
   input  logic              i_run_wait_finished,
   output logic              o_run_busy,
   output logic [AWIDTH:0]   o_run_done_count,
   output logic              o_fifo_check_finished_req,
   input  logic              i_fifo_check_finished_busy,
   input  logic              i_fifo_check_finished_return,
   output logic              o_fifo_deque_req,
   input  logic              i_fifo_deque_busy,
   input  logic [DWIDTH-1:0] i_fifo_deque_return,
   input  logic [AWIDTH-1:0] i_ram_addr_0,
   input  logic [DWIDTH-1:0] i_ram_datain_0,
   input  logic              i_ram_r_w_0,
   output logic [DWIDTH-1:0] o_ram_dataout_0
);

   // One extra address bit keeps WORDS representable when WORDS == 2**AWIDTH.
   localparam logic [AWIDTH:0] WORDS_W = (AWIDTH+1)'(WORDS);
   localparam logic [AWIDTH:0] LAST    = (AWIDTH+1)'(WORDS - 1);

   state_t            state;
   logic [AWIDTH:0]   count_q;
   logic [AWIDTH:0]   addr_ptr;
   logic [DWIDTH-1:0] wr_data;
   logic              wr_en;

   always_ff @(posedge clock) begin
      if (reset) begin
         state                     <= IDLE;
         o_run_busy                <= 1'b0;
         o_run_done_count          <= '0;
         o_fifo_check_finished_req <= 1'b0;
         o_fifo_deque_req          <= 1'b0;
         wr_en                     <= 1'b0;
      end else if (ce) begin
         // Requests are one-cycle pulses raised on entry to a *_REQ state.
         o_fifo_check_finished_req <= 1'b0;
         o_fifo_deque_req          <= 1'b0;
         wr_en                     <= 1'b0;
         case (state)
            IDLE: if (i_run_req) begin
               count_q          <= (i_run_count > WORDS_W) ? WORDS_W : i_run_count;
               addr_ptr         <= ({1'b0, i_run_base} >= WORDS_W) ? '0 : {1'b0, i_run_base};
               o_run_done_count <= '0;
               o_run_busy       <= 1'b1;
               if (i_run_wait_finished) begin
                  state                     <= POLL_REQ;
                  o_fifo_check_finished_req <= 1'b1;
               end else begin
                  state <= CHECK_CNT;
               end
            end
            POLL_REQ:  state <= POLL_HOLD;
            POLL_HOLD: state <= POLL_WAIT;
            POLL_WAIT: if (!i_fifo_check_finished_busy) begin
               if (i_fifo_check_finished_return) begin
                  state <= CHECK_CNT;
               end else begin
                  state                     <= POLL_REQ;
                  o_fifo_check_finished_req <= 1'b1;
               end
            end
            CHECK_CNT: if (o_run_done_count == count_q) begin
               state <= DONE;
            end else begin
               state            <= DEQ_REQ;
               o_fifo_deque_req <= 1'b1;
            end
            DEQ_REQ:  state <= DEQ_HOLD;
            DEQ_HOLD: state <= DEQ_WAIT;
            DEQ_WAIT: if (!i_fifo_deque_busy) begin
               wr_data <= i_fifo_deque_return;
               wr_en   <= 1'b1;
               state   <= WRITE;
            end
            WRITE: begin
               o_run_done_count <= o_run_done_count + 1'b1;
               addr_ptr         <= (addr_ptr == LAST) ? '0 : addr_ptr + 1'b1;
               state            <= CHECK_CNT;
            end
            DONE: begin
               o_run_busy <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   dual_port_ram #(
      .DWIDTH (DWIDTH),
      .AWIDTH (AWIDTH),
      .WORDS  (WORDS)
   ) u_ram (
      .clock     (clock),
      .ce_0      (ce),
      .addr_0    (i_ram_addr_0),
      .datain_0  (i_ram_datain_0),
      .r_w_0     (i_ram_r_w_0),
      .dataout_0 (o_ram_dataout_0),
      .ce_1      (ce),
      .addr_1    (addr_ptr[AWIDTH-1:0]),
      .datain_1  (wr_data),
      .r_w_1     (wr_en)
   );

endmodule

// File: tb/tb_fifo_drain_ram.sv
// Directed bench: FIFO responder, RAM content model and per-cycle output checks.
module tb_fifo_drain_ram;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int WORDS = 10;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          ce = 1'b1;
   logic          i_run_req = 1'b0;
   logic [AW:0]   i_run_count = '0;
   logic [AW-1:0] i_run_base = '0;
   logic          i_run_wait_finished = 1'b0;
   logic          o_run_busy;
   logic [AW:0]   o_run_done_count;
   logic          o_fifo_check_finished_req;
   logic          i_fifo_check_finished_busy = 1'b0;
   logic          i_fifo_check_finished_return = 1'b0;
   logic          o_fifo_deque_req;
   logic          i_fifo_deque_busy = 1'b0;
   logic [DW-1:0] i_fifo_deque_return = '0;
   logic [AW-1:0] i_ram_addr_0 = '0;
   logic [DW-1:0] i_ram_datain_0 = '0;
   logic          i_ram_r_w_0 = 1'b0;
   logic [DW-1:0] o_ram_dataout_0;

   fifo_drain_ram #(.DWIDTH(DW), .AWIDTH(AW), .WORDS(WORDS)) dut (
      .clock                        (clock),
      .reset                        (reset),
      .ce                           (ce),
      .i_run_req                    (i_run_req),
      .i_run_count                  (i_run_count),
      .i_run_base                   (i_run_base),
      .i_run_wait_finished          (i_run_wait_finished),
      .o_run_busy                   (o_run_busy),
      .o_run_done_count             (o_run_done_count),
      .o_fifo_check_finished_req    (o_fifo_check_finished_req),
      .i_fifo_check_finished_busy   (i_fifo_check_finished_busy),
      .i_fifo_check_finished_return (i_fifo_check_finished_return),
      .o_fifo_deque_req             (o_fifo_deque_req),
      .i_fifo_deque_busy            (i_fifo_deque_busy),
      .i_fifo_deque_return          (i_fifo_deque_return),
      .i_ram_addr_0                 (i_ram_addr_0),
      .i_ram_datain_0               (i_ram_datain_0),
      .i_ram_r_w_0                  (i_ram_r_w_0),
      .o_ram_dataout_0              (o_ram_dataout_0)
   );

   always #5 clock = ~clock;

   int vectors = 0;
   int miscompares = 0;
   int cur_cap = WORDS;

   logic [DW-1:0] exp_ram [WORDS];
   bit            exp_valid [WORDS];

   // FIFO responder state
   logic [DW-1:0] deq_q[$];
   bit            chk_q[$];
   int deq_calls = 0;
   int chk_calls = 0;
   int run_deq = 0;
   int chk_at_first_deq = -1;
   int stall_idx = -1;
   int stall_len = 0;
   int rem = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   // FIFO model: acts on requests seen in ce-active cycles; stall_len adds that many WAIT cycles.
   always @(negedge clock) begin
      if (reset) begin
         rem = 0;
         i_fifo_deque_busy = 1'b0;
      end else if (ce) begin
         if (o_fifo_deque_req) begin
            int s;
            if (run_deq == 0) chk_at_first_deq = chk_calls;
            s = (run_deq == stall_idx) ? stall_len : 0;
            i_fifo_deque_return = (deq_q.size() > 0) ? deq_q.pop_front() : 32'hBAD0_BAD0;
            rem = (s > 0) ? s + 2 : 0;
            i_fifo_deque_busy = (s > 0);
            deq_calls++;
            run_deq++;
         end else if (rem > 0) begin
            rem--;
            i_fifo_deque_busy = (rem > 0);
         end
         if (o_fifo_check_finished_req) begin
            chk_calls++;
            i_fifo_check_finished_return = (chk_q.size() > 0) ? chk_q.pop_front() : 1'b1;
         end
      end
   end

   // Every cycle: no request outside a run, and done_count never exceeds the clamped count.
   always @(negedge clock) begin
      if (!reset) begin
         if (o_run_busy)
            check("done_le_cap", 32'(o_run_done_count <= (AW+1)'(cur_cap)), 32'd1);
         else
            check("idle_no_req", {30'd0, o_fifo_deque_req, o_fifo_check_finished_req}, 32'd0);
      end
   end

   // Spec-level model: words land at (base'+i) mod WORDS with clamped count and base.
   task automatic model_write(input int cnt, input int base, input logic [DW-1:0] w[$]);
      int n, b;
      n = (cnt > WORDS) ? WORDS : cnt;
      b = (base >= WORDS) ? 0 : base;
      for (int i = 0; i < n; i++) begin
         exp_ram[(b + i) % WORDS] = w[i];
         exp_valid[(b + i) % WORDS] = 1'b1;
      end
   endtask

   task automatic read_check(input int a, input logic [DW-1:0] exp, input string name);
      @(posedge clock); #1;
      i_ram_addr_0 = AW'(a);
      i_ram_r_w_0  = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check(name, o_ram_dataout_0, exp);
   endtask

   task automatic check_ram();
      for (int a = 0; a < WORDS; a++)
         if (exp_valid[a]) read_check(a, exp_ram[a], $sformatf("ram[%0d]", a));
   endtask

   task automatic run(input int cnt, input int base, input bit wf, input int exp_busy,
                      input int exp_deq, input string name);
      int busy_cyc, guard, n0;
      busy_cyc = 0;
      guard = 0;
      n0 = deq_calls;
      cur_cap = (cnt > WORDS) ? WORDS : cnt;
      run_deq = 0;
      @(posedge clock); #1;
      i_run_req = 1'b1;
      i_run_count = (AW+1)'(cnt);
      i_run_base = AW'(base);
      i_run_wait_finished = wf;
      @(posedge clock); #1;
      i_run_req = 1'b0;
      @(negedge clock);
      while (o_run_busy && guard < 1000) begin
         busy_cyc++;
         guard++;
         @(negedge clock);
      end
      check({name, "_busy_cycles"}, 32'(busy_cyc), 32'(exp_busy));
      check({name, "_deques"}, 32'(deq_calls - n0), 32'(exp_deq));
      check({name, "_done_count"}, 32'(o_run_done_count), 32'(cur_cap));
   endtask

   task automatic load(input int first, input int n, output logic [DW-1:0] w[$]);
      w = {};
      for (int i = 0; i < n; i++) begin
         w.push_back(DW'(first + i));
         deq_q.push_back(DW'(first + i));
      end
   endtask

   initial begin
      logic [DW-1:0] w[$];
      int g;

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      check("rst_busy", 32'(o_run_busy), 32'd0);
      check("rst_done", 32'(o_run_done_count), 32'd0);
      check("rst_deq_req", 32'(o_fifo_deque_req), 32'd0);
      check("rst_chk_req", 32'(o_fifo_check_finished_req), 32'd0);

      // 1: plain 10-word drain; a start pulse mid-run must be ignored
      load(100, 10, w);
      fork
         run(10, 0, 1'b0, 52, 10, "t1");
         begin
            repeat (10) @(posedge clock);
            #1 i_run_req = 1'b1; i_run_count = 5'd3; i_run_base = 4'd5;
            @(posedge clock); #1 i_run_req = 1'b0;
         end
      join
      model_write(10, 0, w);
      repeat (3) @(negedge clock);
      check("t1_not_queued", 32'(o_run_busy), 32'd0);
      check_ram();
      read_check(9, 32'd109, "t1_lit_ram9");

      // 2: poll returns 0,0,1 before draining 4 words
      chk_calls = 0;
      chk_q = {1'b0, 1'b0, 1'b1};
      load(200, 4, w);
      run(4, 0, 1'b1, 31, 4, "t2");
      check("t2_chk_calls", 32'(chk_calls), 32'd3);
      check("t2_chk_before_deq", 32'(chk_at_first_deq), 32'd3);
      model_write(4, 0, w);
      check_ram();

      // 3: base 7, count 5 wraps to 0,1
      load(1, 5, w);
      run(5, 7, 1'b0, 27, 5, "t3");
      model_write(5, 7, w);
      check_ram();
      read_check(0, 32'd4, "t3_lit_ram0");
      read_check(6, 32'd106, "t3_lit_ram6");

      // 4: count 0 then count 15 with out-of-range base 12
      run(0, 4, 1'b0, 2, 0, "t4a");
      load(300, 10, w);
      run(15, 12, 1'b0, 52, 10, "t4b");
      model_write(15, 12, w);
      check_ram();

      // 5: 6-cycle stall on word 3 plus a 4-cycle ce drop
      stall_idx = 2;
      stall_len = 6;
      load(400, 10, w);
      fork
         run(10, 3, 1'b0, 62, 10, "t5");
         begin
            repeat (30) @(posedge clock);
            #1 ce = 1'b0;
            repeat (4) @(posedge clock);
            #1 ce = 1'b1;
         end
      join
      stall_idx = -1;
      stall_len = 0;
      model_write(10, 3, w);
      check_ram();

      // 6: reset during DEQ_WAIT of word 4
      load(500, 10, w);
      cur_cap = 10;
      run_deq = 0;
      g = deq_calls + 4;
      @(posedge clock); #1;
      i_run_req = 1'b1; i_run_count = 5'd10; i_run_base = 4'd0; i_run_wait_finished = 1'b0;
      @(posedge clock); #1 i_run_req = 1'b0;
      for (int k = 0; k < 200 && deq_calls < g; k++) @(posedge clock);
      check("t6_reached_word4", 32'(deq_calls >= g), 32'd1);
      #1;
      @(posedge clock); #1 reset = 1'b1;
      @(posedge clock); #1 reset = 1'b0;
      @(negedge clock);
      check("t6_busy", 32'(o_run_busy), 32'd0);
      check("t6_deq_req", 32'(o_fifo_deque_req), 32'd0);
      check("t6_chk_req", 32'(o_fifo_check_finished_req), 32'd0);
      check("t6_done", 32'(o_run_done_count), 32'd0);
      deq_q.delete();
      model_write(3, 0, w);
      check_ram();
      read_check(3, 32'd400, "t6_lit_ram3");
      load(600, 2, w);
      run(2, 8, 1'b0, 12, 2, "t6_rerun");
      model_write(2, 8, w);
      check_ram();

      // host port: read-during-write returns old data
      @(posedge clock); #1;
      i_ram_addr_0 = 4'd5; i_ram_datain_0 = 32'hDEAD; i_ram_r_w_0 = 1'b1;
      @(posedge clock); #1;
      i_ram_datain_0 = 32'hBEEF;
      @(posedge clock); #1;
      i_ram_r_w_0 = 1'b0;
      @(negedge clock);
      check("host_rdw_old", o_ram_dataout_0, 32'hDEAD);
      @(posedge clock);
      @(negedge clock);
      check("host_new", o_ram_dataout_0, 32'hBEEF);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, limit 500000");
      $fatal(1);
   end

endmodule
